// File: rtl/calc_operand_sequencer.sv
// calc_operand_sequencer
//
// Sequential front-end for the combinational W-bit calculator. Operands A and B
// and a 3-bit opcode are entered one at a time on the shared din bus, one entry
// per rising edge of the debounced load level. The entered values are held on
// the calc_* outputs; one cycle after the opcode is entered, the calculator's
// result and overflow are captured and presented with result_valid and a
// single-cycle done pulse.
//
// Optional feature: define CALC_CHAIN_EN to make a new entry from the result
// display reuse the previous result as operand A (running totals).
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   din          shared entry bus (A, then B, then opcode in din[2:0])
//   load         debounced button level; its rising edge is one entry
//   clr          synchronous abort back to operand-A entry
//   calc_a/b/op  registered operands and opcode to the calculator
//   calc_r/ovf   calculator result and overflow (combinational)
//   result/ovf   captured result and overflow
//   result_valid high while result/ovf hold a valid capture
//   done         one-cycle pulse on capture
//   stage        current state encoding, for display
//   op_count     completed operations, saturating

module calc_operand_sequencer #(
  parameter int unsigned W  = 16,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  din,
  input  logic          load,
  input  logic          clr,
  output logic [W-1:0]  calc_a,
  output logic [W-1:0]  calc_b,
  output logic [2:0]    calc_op,
  input  logic [W-1:0]  calc_r,
  input  logic          calc_ovf,
  output logic [W-1:0]  result,
  output logic          ovf,
  output logic          result_valid,
  output logic          done,
  output logic [2:0]    stage,
  output logic [CW-1:0] op_count
);

  typedef enum logic [2:0] {
    StWaitA  = 3'd0,
    StWaitB  = 3'd1,
    StWaitOp = 3'd2,
    StExec   = 3'd3,
    StShow   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  calc_a_q, calc_a_d;
  logic [W-1:0]  calc_b_q, calc_b_d;
  logic [2:0]    calc_op_q, calc_op_d;
  logic [W-1:0]  result_q, result_d;
  logic          ovf_q, ovf_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic [CW-1:0] op_count_q, op_count_d;
  logic          load_q, load_d;
  logic          ev;

  // One entry per rising edge of the load level.
  assign load_d = load;
  assign ev     = load & ~load_q;

  always_comb begin
    state_d    = state_q;
    calc_a_d   = calc_a_q;
    calc_b_d   = calc_b_q;
    calc_op_d  = calc_op_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    op_count_d = op_count_q;

    if (clr) begin
      // Abort wins over a simultaneous entry; entered operands stay visible.
      state_d = StWaitA;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StWaitA: begin
          if (ev) begin
            calc_a_d = din;
            state_d  = StWaitB;
          end
        end
        StWaitB: begin
          if (ev) begin
            calc_b_d = din;
            state_d  = StWaitOp;
          end
        end
        StWaitOp: begin
          if (ev) begin
            calc_op_d = din[2:0];
            state_d   = StExec;
          end
        end
        StExec: begin
          // Calculator inputs have been stable for a full cycle here.
          result_d = calc_r;
          ovf_d    = calc_ovf;
          valid_d  = 1'b1;
          done_d   = 1'b1;
          if (op_count_q != {CW{1'b1}}) begin
            op_count_d = op_count_q + 1'b1;
          end
          state_d = StShow;
        end
        StShow: begin
          if (ev) begin
            valid_d = 1'b0;
`ifdef CALC_CHAIN_EN
            calc_a_d = result_q;
            calc_b_d = din;
            state_d  = StWaitOp;
`else
            calc_a_d = din;
            state_d  = StWaitB;
`endif
          end
        end
        default: begin
          state_d = StWaitA;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StWaitA;
      calc_a_q   <= '0;
      calc_b_q   <= '0;
      calc_op_q  <= '0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      calc_a_q   <= calc_a_d;
      calc_b_q   <= calc_b_d;
      calc_op_q  <= calc_op_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      op_count_q <= op_count_d;
    end
  end

  // load_q follows load even during reset (it is 0 whenever load is low), so a
  // button already held when reset releases yields no entry until it is
  // released and pressed again.
  always_ff @(posedge clk) begin
    load_q <= load_d;
  end

  assign calc_a       = calc_a_q;
  assign calc_b       = calc_b_q;
  assign calc_op      = calc_op_q;
  assign result       = result_q;
  assign ovf          = ovf_q;
  assign result_valid = valid_q;
  assign done         = done_q;
  assign stage        = state_q;
  assign op_count     = op_count_q;

endmodule
